// File: rtl/rca_reg_config_store.sv
// rca_reg_config_store
//   Per-RCA store of the CPU source/destination register addresses used by RCA
//   "use" instructions. Each RCA owns a shadow bank (written by config
//   instructions) and an active bank (read by the RCA unit). A commit copies the
//   shadow bank of one RCA into its active bank in a single cycle, but only after
//   every in-flight use instruction of that RCA has retired.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cfg_valid/cfg_ready           config write handshake into the shadow bank
//   cfg_rca_sel, cfg_dest         target RCA; 0 = source slot, 1 = destination slot
//   cfg_port_sel, cfg_reg_addr    slot index and register address to store
//   commit_req/commit_ready       commit handshake, commit_rca selects the RCA
//   commit_done                   one-cycle pulse after the shadow->active copy
//   use_issue/use_ready           use instruction issue to use_rca_sel
//   use_complete                  use instruction retired on complete_rca_sel
//   rd_rca_sel                    selects which active bank drives the read outputs
//   src_addrs, dest_addrs         registered active addresses, slot i at [5*i +: 5]
//   entry_valid                   per-RCA: committed at least once since reset
//   busy                          per-RCA: in-flight count non-zero
//   underflow_err                 sticky: retire seen on an RCA with nothing in flight
module rca_reg_config_store #(
  parameter int unsigned NUM_RCAS        = 4,
  parameter int unsigned NUM_READ_PORTS  = 5,
  parameter int unsigned NUM_WRITE_PORTS = 5,
  parameter int unsigned MAX_INFLIGHT    = 4,
  localparam int unsigned RCA_W     = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int unsigned MAX_PORTS = (NUM_READ_PORTS > NUM_WRITE_PORTS) ?
                                      NUM_READ_PORTS : NUM_WRITE_PORTS,
  localparam int unsigned PORT_W    = (MAX_PORTS > 1) ? $clog2(MAX_PORTS) : 1,
  localparam int unsigned CNT_W     = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [RCA_W-1:0]             cfg_rca_sel,
  input  logic                         cfg_dest,
  input  logic [PORT_W-1:0]            cfg_port_sel,
  input  logic [4:0]                   cfg_reg_addr,

  input  logic                         commit_req,
  input  logic [RCA_W-1:0]             commit_rca,
  output logic                         commit_ready,
  output logic                         commit_done,

  input  logic                         use_issue,
  input  logic [RCA_W-1:0]             use_rca_sel,
  output logic                         use_ready,
  input  logic                         use_complete,
  input  logic [RCA_W-1:0]             complete_rca_sel,

  input  logic [RCA_W-1:0]             rd_rca_sel,
  output logic [5*NUM_READ_PORTS-1:0]  src_addrs,
  output logic [5*NUM_WRITE_PORTS-1:0] dest_addrs,
  output logic [NUM_RCAS-1:0]          entry_valid,
  output logic [NUM_RCAS-1:0]          busy,
  output logic                         underflow_err
);

  localparam logic [CNT_W-1:0]  MaxCnt    = CNT_W'(MAX_INFLIGHT);
  localparam logic [PORT_W:0]   RdLimit   = (PORT_W + 1)'(NUM_READ_PORTS);
  localparam logic [PORT_W:0]   WrLimit   = (PORT_W + 1)'(NUM_WRITE_PORTS);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StSwap
  } state_e;

  state_e           state_q;
  logic [RCA_W-1:0] locked_q;

  logic [4:0] shadow_src_q [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0] shadow_dst_q [NUM_RCAS][NUM_WRITE_PORTS];
  logic [4:0] active_src_q [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0] active_dst_q [NUM_RCAS][NUM_WRITE_PORTS];

  logic [CNT_W-1:0] count_q [NUM_RCAS];
  logic [CNT_W-1:0] count_d [NUM_RCAS];

  logic [NUM_RCAS-1:0] issue_hit;
  logic [NUM_RCAS-1:0] complete_hit;
  logic                underflow_set;

  logic lock_active;
  logic cfg_fire;
  logic cfg_src_hit;
  logic cfg_dst_hit;
  logic issue_fire;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // While a commit is pending, the locked RCA is frozen: its shadow bank cannot
  // change under the copy and no new uses can extend the drain.
  assign lock_active  = (state_q != StIdle);
  assign commit_ready = (state_q == StIdle);
  assign cfg_ready    = !(lock_active && (cfg_rca_sel == locked_q));
  assign use_ready    = (count_q[use_rca_sel] != MaxCnt) &&
                        !(lock_active && (use_rca_sel == locked_q));

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign issue_fire = use_issue && use_ready;

  // Out-of-range slot indices complete the handshake but write nothing.
  assign cfg_src_hit = cfg_fire && !cfg_dest && ({1'b0, cfg_port_sel} < RdLimit);
  assign cfg_dst_hit = cfg_fire &&  cfg_dest && ({1'b0, cfg_port_sel} < WrLimit);

  // ---------------------------------------------------------------------------
  // Commit FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      locked_q    <= '0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (commit_req) begin
            locked_q <= commit_rca;
            state_q  <= StDrain;
          end
        end
        // Even a zero count costs one cycle here, so the swap never coincides
        // with the accept edge.
        StDrain: begin
          if (count_q[locked_q] == '0) begin
            state_q <= StSwap;
          end
        end
        StSwap: begin
          state_q     <= StIdle;
          commit_done <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight counters
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_hit    = '0;
    complete_hit = '0;
    for (int unsigned r = 0; r < NUM_RCAS; r++) begin
      issue_hit[r]    = issue_fire && (use_rca_sel == RCA_W'(r));
      complete_hit[r] = use_complete && (complete_rca_sel == RCA_W'(r));
    end
  end

  // A same-cycle issue and retire on one RCA cancel out, so that case never
  // counts as an underflow even when the count is zero.
  always_comb begin
    underflow_set = 1'b0;
    for (int unsigned r = 0; r < NUM_RCAS; r++) begin
      count_d[r] = count_q[r];
      if (issue_hit[r] && !complete_hit[r]) begin
        count_d[r] = count_q[r] + CNT_W'(1);
      end else if (complete_hit[r] && !issue_hit[r]) begin
        if (count_q[r] == '0) begin
          underflow_set = 1'b1;
        end else begin
          count_d[r] = count_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        count_q[r] <= '0;
      end
      underflow_err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        count_q[r] <= count_d[r];
      end
      if (underflow_set) begin
        underflow_err <= 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < NUM_RCAS; r++) begin
      busy[r] = (count_q[r] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and active banks
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
          shadow_src_q[r][i] <= '0;
          active_src_q[r][i] <= '0;
        end
        for (int unsigned i = 0; i < NUM_WRITE_PORTS; i++) begin
          shadow_dst_q[r][i] <= '0;
          active_dst_q[r][i] <= '0;
        end
      end
      entry_valid <= '0;
    end else begin
      if (cfg_src_hit) begin
        shadow_src_q[cfg_rca_sel][cfg_port_sel] <= cfg_reg_addr;
      end
      if (cfg_dst_hit) begin
        shadow_dst_q[cfg_rca_sel][cfg_port_sel] <= cfg_reg_addr;
      end
      // The locked RCA cannot take config writes in this state, so the copy
      // sees a stable shadow bank.
      if (state_q == StSwap) begin
        for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
          active_src_q[locked_q][i] <= shadow_src_q[locked_q][i];
        end
        for (int unsigned i = 0; i < NUM_WRITE_PORTS; i++) begin
          active_dst_q[locked_q][i] <= shadow_dst_q[locked_q][i];
        end
        entry_valid[locked_q] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      src_addrs  <= '0;
      dest_addrs <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
        src_addrs[5*i +: 5] <= active_src_q[rd_rca_sel][i];
      end
      for (int unsigned i = 0; i < NUM_WRITE_PORTS; i++) begin
        dest_addrs[5*i +: 5] <= active_dst_q[rd_rca_sel][i];
      end
    end
  end

endmodule

// File: tb/tb_rca_reg_config_store.sv
module tb_rca_reg_config_store;

  localparam int NR   = 4;
  localparam int NRP  = 5;
  localparam int NWP  = 5;
  localparam int MAXI = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_SWAP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_dest;
  logic [1:0]  cfg_rca_sel;
  logic [2:0]  cfg_port_sel;
  logic [4:0]  cfg_reg_addr;
  logic        commit_req, commit_ready, commit_done;
  logic [1:0]  commit_rca;
  logic        use_issue, use_ready, use_complete;
  logic [1:0]  use_rca_sel, complete_rca_sel, rd_rca_sel;
  logic [24:0] src_addrs, dest_addrs;
  logic [3:0]  entry_valid, busy;
  logic        underflow_err;

  rca_reg_config_store dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_rca_sel      (cfg_rca_sel),
    .cfg_dest         (cfg_dest),
    .cfg_port_sel     (cfg_port_sel),
    .cfg_reg_addr     (cfg_reg_addr),
    .commit_req       (commit_req),
    .commit_rca       (commit_rca),
    .commit_ready     (commit_ready),
    .commit_done      (commit_done),
    .use_issue        (use_issue),
    .use_rca_sel      (use_rca_sel),
    .use_ready        (use_ready),
    .use_complete     (use_complete),
    .complete_rca_sel (complete_rca_sel),
    .rd_rca_sel       (rd_rca_sel),
    .src_addrs        (src_addrs),
    .dest_addrs       (dest_addrs),
    .entry_valid      (entry_valid),
    .busy             (busy),
    .underflow_err    (underflow_err)
  );

  // Reference model: plain arrays and integers.
  int          m_sh_src  [NR][NRP];
  int          m_sh_dst  [NR][NWP];
  int          m_act_src [NR][NRP];
  int          m_act_dst [NR][NWP];
  int          m_cnt     [NR];
  bit          m_ev      [NR];
  bit          m_uf;
  int          m_phase;
  int          m_lock;
  bit          m_done;
  logic [24:0] m_src_q, m_dst_q;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NRP; i++) begin m_sh_src[r][i] = 0; m_act_src[r][i] = 0; end
      for (int i = 0; i < NWP; i++) begin m_sh_dst[r][i] = 0; m_act_dst[r][i] = 0; end
      m_cnt[r] = 0;
      m_ev[r]  = 1'b0;
    end
    m_uf    = 1'b0;
    m_phase = PH_IDLE;
    m_lock  = 0;
    m_done  = 1'b0;
    m_src_q = '0;
    m_dst_q = '0;
  endtask

  function automatic bit locked_on(input int r);
    return (m_phase != PH_IDLE) && (m_lock == r);
  endfunction

  function automatic bit exp_cfg_ready();
    return !locked_on(int'(cfg_rca_sel));
  endfunction

  function automatic bit exp_use_ready();
    return (m_cnt[int'(use_rca_sel)] < MAXI) && !locked_on(int'(use_rca_sel));
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] b;
    for (int r = 0; r < NR; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic logic [3:0] exp_ev();
    logic [3:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_ev[r];
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic m_step();
    bit rdy_cfg, rdy_use;
    int rd, net;
    if (rst) begin
      m_reset();
      return;
    end
    rdy_cfg = exp_cfg_ready();
    rdy_use = exp_use_ready();
    rd = int'(rd_rca_sel);
    for (int i = 0; i < NRP; i++) m_src_q[5*i +: 5] = 5'(m_act_src[rd][i]);
    for (int i = 0; i < NWP; i++) m_dst_q[5*i +: 5] = 5'(m_act_dst[rd][i]);
    m_done = 1'b0;
    if (m_phase == PH_SWAP) begin
      for (int i = 0; i < NRP; i++) m_act_src[m_lock][i] = m_sh_src[m_lock][i];
      for (int i = 0; i < NWP; i++) m_act_dst[m_lock][i] = m_sh_dst[m_lock][i];
      m_ev[m_lock] = 1'b1;
      m_phase = PH_IDLE;
      m_done  = 1'b1;
    end else if (m_phase == PH_DRAIN) begin
      if (m_cnt[m_lock] == 0) m_phase = PH_SWAP;
    end else if (commit_req) begin
      m_lock  = int'(commit_rca);
      m_phase = PH_DRAIN;
    end
    if (cfg_valid && rdy_cfg) begin
      if (!cfg_dest && int'(cfg_port_sel) < NRP)
        m_sh_src[cfg_rca_sel][cfg_port_sel] = int'(cfg_reg_addr);
      else if (cfg_dest && int'(cfg_port_sel) < NWP)
        m_sh_dst[cfg_rca_sel][cfg_port_sel] = int'(cfg_reg_addr);
    end
    for (int r = 0; r < NR; r++) begin
      net = 0;
      if (use_issue && rdy_use && int'(use_rca_sel) == r) net = net + 1;
      if (use_complete && int'(complete_rca_sel) == r) net = net - 1;
      if (net < 0 && m_cnt[r] == 0) m_uf = 1'b1;
      else m_cnt[r] = m_cnt[r] + net;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cfg_ready",     32'(cfg_ready),     32'(exp_cfg_ready()));
      chk("use_ready",     32'(use_ready),     32'(exp_use_ready()));
      chk("commit_ready",  32'(commit_ready),  32'(m_phase == PH_IDLE));
      chk("commit_done",   32'(commit_done),   32'(m_done));
      chk("src_addrs",     32'(src_addrs),     32'(m_src_q));
      chk("dest_addrs",    32'(dest_addrs),    32'(m_dst_q));
      chk("entry_valid",   32'(entry_valid),   32'(exp_ev()));
      chk("busy",          32'(busy),          32'(exp_busy()));
      chk("underflow_err", 32'(underflow_err), 32'(m_uf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_step();
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_dest = 1'b0; cfg_rca_sel = '0; cfg_port_sel = '0; cfg_reg_addr = '0;
    commit_req = 1'b0; commit_rca = '0;
    use_issue = 1'b0; use_rca_sel = '0; use_complete = 1'b0; complete_rca_sel = '0;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_rca_sel = '0;
    idle_inputs();
    m_reset();
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    mid();
    chk("reset src_addrs", 32'(src_addrs), 32'h0);
    chk("reset entry_valid", 32'(entry_valid), 32'h0);
    chk("reset commit_ready", 32'(commit_ready), 32'h1);

    // 1: write src slot 2 of RCA1, commit, read back.
    cfg_valid = 1'b1; cfg_rca_sel = 2'd1; cfg_port_sel = 3'd2; cfg_reg_addr = 5'd7;
    tick();
    cfg_valid = 1'b0; commit_req = 1'b1; commit_rca = 2'd1; rd_rca_sel = 2'd1;
    tick();
    commit_req = 1'b0;
    mid();
    chk("t1 commit_ready locked", 32'(commit_ready), 32'h0);
    tick();
    tick();
    mid();
    chk("t1 commit_done", 32'(commit_done), 32'h1);
    chk("t1 entry_valid", 32'(entry_valid), 32'h2);
    tick();
    mid();
    chk("t1 src slot2", 32'(src_addrs[14:10]), 32'd7);
    chk("t1 done pulse ends", 32'(commit_done), 32'h0);

    // 2: two uses in flight on RCA0 hold the commit in drain.
    use_issue = 1'b1; use_rca_sel = 2'd0;
    tick();
    tick();
    use_issue = 1'b0; commit_req = 1'b1; commit_rca = 2'd0;
    tick();
    commit_req = 1'b0;
    mid();
    chk("t2 use_ready blocked", 32'(use_ready), 32'h0);
    tick();
    tick();
    mid();
    chk("t2 still draining", 32'(commit_ready), 32'h0);
    use_complete = 1'b1; complete_rca_sel = 2'd0;
    tick();
    tick();
    use_complete = 1'b0;
    tick();
    tick();
    mid();
    chk("t2 commit_done", 32'(commit_done), 32'h1);

    // 3: fill RCA3, then same-cycle issue+complete at count 3.
    use_issue = 1'b1; use_rca_sel = 2'd3;
    repeat (4) tick();
    use_issue = 1'b0;
    mid();
    chk("t3 full use_ready", 32'(use_ready), 32'h0);
    use_complete = 1'b1; complete_rca_sel = 2'd3;
    tick();
    use_issue = 1'b1;
    tick();
    use_issue = 1'b0; use_complete = 1'b0;
    mid();
    chk("t3 count 3 ready", 32'(use_ready), 32'h1);
    use_issue = 1'b1;
    tick();
    use_issue = 1'b0;
    mid();
    chk("t3 count 4 not ready", 32'(use_ready), 32'h0);
    use_complete = 1'b1;
    repeat (4) tick();
    use_complete = 1'b0;

    // 4: config to a draining RCA is held off; another RCA is accepted.
    commit_req = 1'b1; commit_rca = 2'd2;
    tick();
    commit_req = 1'b0;
    cfg_valid = 1'b1; cfg_rca_sel = 2'd2; cfg_dest = 1'b1; cfg_port_sel = 3'd4; cfg_reg_addr = 5'd9;
    mid();
    chk("t4 cfg locked", 32'(cfg_ready), 32'h0);
    cfg_rca_sel = 2'd1;
    #1;
    chk("t4 cfg other", 32'(cfg_ready), 32'h1);
    tick();
    cfg_valid = 1'b0; cfg_dest = 1'b0;
    repeat (3) tick();

    // 5: retire on an idle RCA.
    use_complete = 1'b1; complete_rca_sel = 2'd0;
    tick();
    use_complete = 1'b0;
    mid();
    chk("t5 underflow_err", 32'(underflow_err), 32'h1);
    chk("t5 busy", 32'(busy), 32'h0);

    // 6: reset mid-drain aborts the commit; a fresh commit then completes.
    use_issue = 1'b1; use_rca_sel = 2'd3;
    tick();
    use_issue = 1'b0; commit_req = 1'b1; commit_rca = 2'd3;
    tick();
    commit_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    chk("t6 no done after rst", 32'(commit_done), 32'h0);
    chk("t6 entry_valid cleared", 32'(entry_valid), 32'h0);
    commit_req = 1'b1; commit_rca = 2'd3;
    tick();
    commit_req = 1'b0;
    tick();
    tick();
    mid();
    chk("t6 commit_done", 32'(commit_done), 32'h1);
    chk("t6 entry_valid", 32'(entry_valid), 32'h8);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 199) == 0);
      cfg_valid        = 1'($urandom_range(0, 1));
      cfg_rca_sel      = 2'($urandom_range(0, 3));
      cfg_dest         = 1'($urandom_range(0, 1));
      cfg_port_sel     = 3'($urandom_range(0, 7));
      cfg_reg_addr     = 5'($urandom_range(0, 31));
      commit_req       = ($urandom_range(0, 9) == 0);
      commit_rca       = 2'($urandom_range(0, 3));
      use_issue        = 1'($urandom_range(0, 1));
      use_rca_sel      = 2'($urandom_range(0, 3));
      complete_rca_sel = 2'($urandom_range(0, 3));
      use_complete     = ($urandom_range(0, 1) == 1) &&
                         (m_cnt[int'(complete_rca_sel)] > 0 || $urandom_range(0, 29) == 0);
      rd_rca_sel       = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
